btb: RTL and testbench

Branch target buffer sitting directly upstream of the fetch stage. It supplies `pred_hit` and `bht_out`, which fetch uses to choose between the predicted target and PC+4. The lookup is indexed combinationally by the current fetch PC. Branch and jump resolution from execute trains the buffer, and the block also keeps resolved-branch and mispredict performance counters.

---
 rtl/btb_if.sv | 26 ++
 rtl/btb.sv | 102 ++++++++++
 tb/tb_btb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_if.sv
// Fetch/execute-side bus of the branch target buffer: lookup, training and perf counters.
interface btb_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      fetch_pc;
    logic             pred_hit;
    logic [31:0]      bht_out;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_mispred;
    logic             inval_all;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred, inval_all,
        input  pred_hit, bht_out, br_count, mispred_count
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred, inval_all,
        output pred_hit, bht_out, br_count, mispred_count
    );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit hysteresis, combinational lookup
// by fetch PC, one-cycle training from execute, and saturating perf counters.
module btb #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic   clk,
    input logic   rst,
    btb_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t ent_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    entry_t           rd_ent;
    entry_t           wr_ent;
    entry_t           wr_next;
    logic             wr_en;
    logic             hit;

    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mis_q;

    // Instruction PCs are word aligned; the low bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    assign rd_idx = bus.fetch_pc[IDX_W+1:2];
    assign rd_tag = bus.fetch_pc[31:IDX_W+2];
    assign wr_idx = bus.upd_pc[IDX_W+1:2];
    assign wr_tag = bus.upd_pc[31:IDX_W+2];
    assign rd_ent = ent_q[rd_idx];
    assign wr_ent = ent_q[wr_idx];

    // Only a strongly/weakly-taken entry predicts; a weak not-taken entry keeps its target.
    assign hit          = rd_ent.valid && (rd_ent.tag == rd_tag) && rd_ent.ctr[1];
    assign bus.pred_hit = hit;
    assign bus.bht_out  = hit ? rd_ent.target : 32'd0;

    // Training: next contents of the indexed entry.
    always_comb begin
        wr_en   = 1'b0;
        wr_next = wr_ent;
        if (bus.upd_valid && !bus.inval_all) begin
            if (wr_ent.valid && (wr_ent.tag == wr_tag)) begin
                wr_en = 1'b1;
                if (bus.upd_taken) begin
                    wr_next.ctr    = (wr_ent.ctr == 2'd3) ? 2'd3 : wr_ent.ctr + 2'd1;
                    wr_next.target = bus.upd_target;
                end else begin
                    wr_next.ctr    = (wr_ent.ctr == 2'd0) ? 2'd0 : wr_ent.ctr - 2'd1;
                end
            end else if (bus.upd_taken) begin
                wr_en   = 1'b1;
                wr_next = '{valid: 1'b1, tag: wr_tag, target: bus.upd_target, ctr: 2'd2};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '{default: '0};
        end else if (bus.inval_all) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_q[IDX_W'(i)].valid <= 1'b0;
            end
        end else if (wr_en) begin
            ent_q[wr_idx] <= wr_next;
        end
    end

    // Perf counters count every resolved CTI, even when an invalidate drops the training.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (bus.upd_valid) begin
            if (br_q != '1) begin
                br_q <= br_q + CNT_W'(1);
            end
            if (bus.upd_mispred && (mis_q != '1)) begin
                mis_q <= mis_q + CNT_W'(1);
            end
        end
    end

    assign bus.br_count      = br_q;
    assign bus.mispred_count = mis_q;

endmodule

// File: tb/tb_btb.sv
// Scoreboard bench for btb: a reference model predicts each cycle's lookup and
// counters; a second 4-bit-counter instance covers counter saturation.
module tb_btb;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = 32 - 2 - IDX_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_if #(.CNT_W(32)) bus ();
    btb_if #(.CNT_W(4))  bus4 ();

    btb #(.ENTRIES(ENTRIES), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    btb #(.ENTRIES(ENTRIES), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.fetch_pc    = bus.fetch_pc;
    assign bus4.upd_valid   = bus.upd_valid;
    assign bus4.upd_pc      = bus.upd_pc;
    assign bus4.upd_target  = bus.upd_target;
    assign bus4.upd_taken   = bus.upd_taken;
    assign bus4.upd_mispred = bus.upd_mispred;
    assign bus4.inval_all   = bus.inval_all;

    typedef struct {
        logic        hit;
        logic [31:0] tgt;
        logic [31:0] br;
        logic [31:0] mis;
        logic [3:0]  br4;
        logic [3:0]  mis4;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    bit               m_valid [ENTRIES];
    logic [TAG_W-1:0] m_tag   [ENTRIES];
    logic [31:0]      m_tgt   [ENTRIES];
    int               m_ctr   [ENTRIES];
    longint unsigned  m_br, m_mis;
    int               m_br4, m_mis4;

    logic        last_hit;
    logic [31:0] last_tgt;
    logic [31:0] last_br;
    logic [31:0] last_mis;
    logic [3:0]  last_br4;
    logic [3:0]  last_mis4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        m_br = 0; m_mis = 0; m_br4 = 0; m_mis4 = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit,
                                         output logic [31:0] tgt);
        int idx;
        idx = int'(pc[IDX_W+1:2]);
        hit = m_valid[idx] && (m_tag[idx] == pc[31:IDX_W+2]) && (m_ctr[idx] >= 2);
        tgt = hit ? m_tgt[idx] : 32'd0;
    endfunction

    function automatic void model_update(input bit uv, input logic [31:0] upc,
                                         input logic [31:0] utgt, input bit ut,
                                         input bit um, input bit inv, input bit r);
        int idx;
        if (r) begin
            model_reset();
            return;
        end
        if (uv) begin
            if (m_br != 64'hFFFF_FFFF) m_br++;
            if (m_br4 != 15) m_br4++;
            if (um) begin
                if (m_mis != 64'hFFFF_FFFF) m_mis++;
                if (m_mis4 != 15) m_mis4++;
            end
        end
        if (inv) begin
            for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
        end else if (uv) begin
            idx = int'(upc[IDX_W+1:2]);
            if (m_valid[idx] && (m_tag[idx] == upc[31:IDX_W+2])) begin
                if (ut) begin
                    if (m_ctr[idx] < 3) m_ctr[idx]++;
                    m_tgt[idx] = utgt;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else if (ut) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = upc[31:IDX_W+2];
                m_tgt[idx]   = utgt;
                m_ctr[idx]   = 2;
            end
        end
    endfunction

    // One clock: drive, push expectation, compare at negedge, then advance the model.
    task automatic cycle(input string name, input logic [31:0] pc, input bit uv = 0,
                         input logic [31:0] upc = 0, input logic [31:0] utgt = 0,
                         input bit ut = 0, input bit um = 0, input bit inv = 0,
                         input bit r = 0);
        exp_t e;
        bus.fetch_pc    = pc;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_target  = utgt;
        bus.upd_taken   = ut;
        bus.upd_mispred = um;
        bus.inval_all   = inv;
        rst             = r;
        model_lookup(pc, e.hit, e.tgt);
        e.br   = 32'(m_br);
        e.mis  = 32'(m_mis);
        e.br4  = 4'(m_br4);
        e.mis4 = 4'(m_mis4);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        last_hit  = bus.pred_hit;
        last_tgt  = bus.bht_out;
        last_br   = bus.br_count;
        last_mis  = bus.mispred_count;
        last_br4  = bus4.br_count;
        last_mis4 = bus4.mispred_count;
        check({name, ".hit"},  64'(last_hit),      64'(e.hit));
        check({name, ".tgt"},  64'(last_tgt),      64'(e.tgt));
        check({name, ".br"},   64'(last_br),       64'(e.br));
        check({name, ".mis"},  64'(last_mis),      64'(e.mis));
        check({name, ".br4"},  64'(last_br4),      64'(e.br4));
        check({name, ".mis4"}, 64'(last_mis4),     64'(e.mis4));
        check({name, ".hit4"}, 64'(bus4.pred_hit), 64'(e.hit));
        model_update(uv, upc, utgt, ut, um, inv, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rpc, rupc;
        bus.fetch_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
        bus.upd_taken = 1'b0; bus.upd_mispred = 1'b0; bus.inval_all = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        cycle("cold", 32'h60);
        check("cold_hit", 64'(last_hit), 64'd0);
        check("cold_tgt", 64'(last_tgt), 64'd0);
        check("cold_br",  64'(last_br),  64'd0);
        check("cold_mis", 64'(last_mis), 64'd0);

        cycle("alloc", 32'h60, 1, 32'h60, 32'h100, 1);
        cycle("hit", 32'h60);
        check("alloc_hit", 64'(last_hit), 64'd1);
        check("alloc_tgt", 64'(last_tgt), 64'h100);
        cycle("alias", 32'h60 + 32'(4 * ENTRIES));
        check("alias_hit", 64'(last_hit), 64'd0);

        cycle("nt1", 32'h60, 1, 32'h60, 32'h0, 0);
        cycle("weak", 32'h60);
        check("weak_hit", 64'(last_hit), 64'd0);
        cycle("t1", 32'h60, 1, 32'h60, 32'h100, 1);
        cycle("rehit", 32'h60);
        check("rehit_hit", 64'(last_hit), 64'd1);
        for (int i = 0; i < 3; i++) cycle("tsat", 32'h0, 1, 32'h60, 32'h100, 1);
        cycle("nt2", 32'h0, 1, 32'h60, 32'h0, 0);
        cycle("strong", 32'h60);
        check("strong_hit", 64'(last_hit), 64'd1);

        cycle("ntmiss", 32'h0, 1, 32'h80, 32'h180, 0);
        cycle("ntmiss_lk", 32'h80);
        check("ntmiss_hit", 64'(last_hit), 64'd0);

        cycle("evict", 32'h0, 1, 32'hA0, 32'h200, 1, 1);
        cycle("evict_old", 32'h60);
        check("evict_old_hit", 64'(last_hit), 64'd0);
        cycle("evict_new", 32'hA0);
        check("evict_new_tgt", 64'(last_tgt), 64'h200);

        cycle("haz", 32'hA0, 1, 32'hA0, 32'h240, 1);
        check("haz_old_tgt", 64'(last_tgt), 64'h200);
        cycle("haz_next", 32'hA0);
        check("haz_new_tgt", 64'(last_tgt), 64'h240);

        cycle("alloc80", 32'h0, 1, 32'h80, 32'h300, 1);
        cycle("inval", 32'h80, 1, 32'h40, 32'h400, 1, 0, 1);
        cycle("inval_40", 32'h40);
        check("inval_40_hit", 64'(last_hit), 64'd0);
        cycle("inval_80", 32'h80);
        check("inval_80_hit", 64'(last_hit), 64'd0);
        cycle("inval_a0", 32'hA0);
        check("inval_a0_hit", 64'(last_hit), 64'd0);
        check("inval_br", 64'(last_br), 64'd12);

        for (int i = 0; i < 60; i++) begin
            rpc  = 32'($urandom_range(0, 31)) << 2;
            rupc = 32'($urandom_range(0, 31)) << 2;
            cycle("rand", rpc, 1'($urandom_range(0, 1)), rupc, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
        end

        cycle("mid_rst", 32'h60, 1, 32'h60, 32'h500, 1, 1, 1, 1);
        cycle("post_rst", 32'h60);
        check("post_rst_hit", 64'(last_hit), 64'd0);
        check("post_rst_br",  64'(last_br),  64'd0);

        for (int i = 0; i < 5; i++) cycle("cnt5", 32'h0, 1, 32'h44, 32'h0, 0, i < 2);
        cycle("cnt5_chk", 32'h0);
        check("cnt5_br",  64'(last_br),  64'd5);
        check("cnt5_mis", 64'(last_mis), 64'd2);

        for (int i = 0; i < 20; i++) cycle("cnt20", 32'h0, 1, 32'h48, 32'h0, 0, (i % 2) == 0);
        cycle("cnt20_chk", 32'h0);
        check("sat_br4",  64'(last_br4),  64'd15);
        check("sat_mis4", 64'(last_mis4), 64'd12);
        check("sat_br",   64'(last_br),   64'd25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
